// File: rtl/gf180mcu_fd_sc_mcu7t5v0__demux3_rr.sv
// gf180mcu_fd_sc_mcu7t5v0__demux3_rr
// One-input, three-output demultiplexer with a registered single-entry
// buffer per output channel (A, B, C). The target channel comes from SEL
// (addressed mode) or from a round-robin pointer (round-robin mode).
// SEL=3 in addressed mode is illegal. It is refused, and ERR pulses for one cycle.
// Optional feature: define GF180MCU_DEMUX3_XFER_CNT_EN to add the
// saturating 8-bit XFER_CNT output. It counts accepted input transfers.
module gf180mcu_fd_sc_mcu7t5v0__demux3_rr #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [WIDTH-1:0] I_DATA,
    input  logic             MODE,
    input  logic [1:0]       SEL,
    output logic             ZA_VALID,
    output logic             ZB_VALID,
    output logic             ZC_VALID,
    input  logic             ZA_READY,
    input  logic             ZB_READY,
    input  logic             ZC_READY,
    output logic [WIDTH-1:0] ZA_DATA,
    output logic [WIDTH-1:0] ZB_DATA,
    output logic [WIDTH-1:0] ZC_DATA,
`ifdef GF180MCU_DEMUX3_XFER_CNT_EN
    output logic [7:0]       XFER_CNT,
`endif
    output logic             ERR
);

    typedef enum logic [1:0] {
        RR_A = 2'd0,
        RR_B = 2'd1,
        RR_C = 2'd2
    } rr_state_t;

    rr_state_t        rr_state_r;
    rr_state_t        rr_next_s;
    logic [2:0]       valid_r;
    logic [WIDTH-1:0] data_a_r;
    logic [WIDTH-1:0] data_b_r;
    logic [WIDTH-1:0] data_c_r;
    logic             err_r;
    logic [2:0]       sink_ready_s;
    logic [1:0]       target_s;
    logic             illegal_s;
    logic             target_full_s;
    logic             target_sink_s;
    logic             xfer_s;
    logic [2:0]       load_s;
    logic [2:0]       drain_s;

    assign sink_ready_s = {ZC_READY, ZB_READY, ZA_READY};

    // Pick the target channel and decide whether the input word can be taken.
    always_comb begin
        target_s      = 2'd0;
        illegal_s     = 1'b0;
        target_full_s = 1'b0;
        target_sink_s = 1'b0;
        if (MODE) begin
            case (rr_state_r)
                RR_A:    target_s = 2'd0;
                RR_B:    target_s = 2'd1;
                RR_C:    target_s = 2'd2;
                default: target_s = 2'd0;
            endcase
        end else begin
            if (SEL == 2'd3) begin
                illegal_s = 1'b1;
            end else begin
                target_s = SEL;
            end
        end
        case (target_s)
            2'd0: begin
                target_full_s = valid_r[0];
                target_sink_s = sink_ready_s[0];
            end
            2'd1: begin
                target_full_s = valid_r[1];
                target_sink_s = sink_ready_s[1];
            end
            2'd2: begin
                target_full_s = valid_r[2];
                target_sink_s = sink_ready_s[2];
            end
            default: begin
                target_full_s = 1'b1;
                target_sink_s = 1'b0;
            end
        endcase
    end

    // Ready is gated by RN, so the input is refused while reset is held.
    assign I_READY = RN & ~illegal_s & (~target_full_s | target_sink_s);
    assign xfer_s  = I_VALID & I_READY;
    assign load_s  = xfer_s ? (3'b001 << target_s) : 3'b000;
    assign drain_s = valid_r & sink_ready_s;

    // Channel buffers. A load in the same cycle as a drain keeps the buffer full, so no bubble appears.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            valid_r  <= 3'b000;
            data_a_r <= {WIDTH{1'b0}};
            data_b_r <= {WIDTH{1'b0}};
            data_c_r <= {WIDTH{1'b0}};
        end else begin
            valid_r <= load_s | (valid_r & ~drain_s);
            if (load_s[0]) begin
                data_a_r <= I_DATA;
            end
            if (load_s[1]) begin
                data_b_r <= I_DATA;
            end
            if (load_s[2]) begin
                data_c_r <= I_DATA;
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            rr_state_r <= RR_A;
        end else begin
            rr_state_r <= rr_next_s;
        end
    end

    // Round-robin next state: advance only on an accepted transfer in round-robin mode.
    always_comb begin
        rr_next_s = rr_state_r;
        if (xfer_s && MODE) begin
            case (rr_state_r)
                RR_A:    rr_next_s = RR_B;
                RR_B:    rr_next_s = RR_C;
                RR_C:    rr_next_s = RR_A;
                default: rr_next_s = RR_A;
            endcase
        end else begin
            rr_next_s = rr_state_r;
        end
    end

    // Error pulse for the cycle after each illegal addressed request.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            err_r <= 1'b0;
        end else begin
            err_r <= I_VALID & illegal_s;
        end
    end

`ifdef GF180MCU_DEMUX3_XFER_CNT_EN
    logic [7:0] xfer_cnt_r;

    // Accepted-transfer counter. It saturates at 255 and is not changed by drains.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            xfer_cnt_r <= 8'd0;
        end else if (xfer_s && (xfer_cnt_r != 8'd255)) begin
            xfer_cnt_r <= xfer_cnt_r + 8'd1;
        end
    end

    assign XFER_CNT = xfer_cnt_r;
`endif

    assign ZA_VALID = valid_r[0];
    assign ZB_VALID = valid_r[1];
    assign ZC_VALID = valid_r[2];
    assign ZA_DATA  = data_a_r;
    assign ZB_DATA  = data_b_r;
    assign ZC_DATA  = data_c_r;
    assign ERR      = err_r;

endmodule
